// File: rtl/operation_sequencer.sv
// operation_sequencer
//   Control sequencer for a multiply / divide / square-root datapath. A start
//   request latches the opcode, then one or two operands are captured from
//   data_in on load strobes. After that the datapath is launched with a
//   one-cycle Start pulse, and the sequencer waits up to TIMEOUT cycles for done.
//   An error level from the downstream detector, an invalid opcode or a
//   timeout all park the sequencer in FAULT until the next start.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : one-cycle request to begin an operation
//   load       : one-cycle request to capture data_in as the next operand
//   opcode     : 0 multiply, 1 divide, 2 square root, 3 invalid
//   data_in    : operand source
//   done       : datapath completion strobe
//   error      : downstream error level
//   Start      : one-cycle launch pulse to datapath / error detector
//   LoadData   : one-cycle pulse per operand capture
//   Ready      : result valid
//   Opcode     : opcode latched for the current operation
//   operand_x  : first operand
//   operand_y  : second operand (zero for square root)
//   busy       : operation in progress (collecting operands or running)
//   fault      : sequencer is in FAULT
module operation_sequencer #(
  parameter int WORD_LENGTH = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   load,
  input  logic [1:0]             opcode,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   done,
  input  logic                   error,
  output logic                   Start,
  output logic                   LoadData,
  output logic                   Ready,
  output logic [1:0]             Opcode,
  output logic [WORD_LENGTH-1:0] operand_x,
  output logic [WORD_LENGTH-1:0] operand_y,
  output logic                   busy,
  output logic                   fault
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_X = 3'd1,
    S_WAIT_Y = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   launch_q, launch_d;
  logic                   load_pulse_q, load_pulse_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   fault_q, fault_d;
  logic [1:0]             opcode_q, opcode_d;
  logic [WORD_LENGTH-1:0] x_q, x_d;
  logic [WORD_LENGTH-1:0] y_q, y_d;

  // Where a newly accepted start leads: invalid opcode goes straight to FAULT.
  function automatic state_t start_target(input logic [1:0] op);
    if (op == 2'd3) begin
      start_target = S_FAULT;
    end else begin
      start_target = S_WAIT_X;
    end
  endfunction

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    opcode_d     = opcode_q;
    x_d          = x_q;
    y_d          = y_q;
    launch_d     = 1'b0;
    load_pulse_d = 1'b0;

    case (state_q)
      S_IDLE, S_FAULT: begin
        if (start) begin
          opcode_d = opcode;
          state_d  = start_target(opcode);
        end else begin
          state_d = state_q;
        end
      end

      S_WAIT_X: begin
        if (error) begin
          state_d = S_FAULT;
        end else if (load) begin
          x_d          = data_in;
          load_pulse_d = 1'b1;
          if (opcode_q == 2'd2) begin
            y_d     = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_WAIT_Y;
          end
        end else begin
          state_d = S_WAIT_X;
        end
      end

      S_WAIT_Y: begin
        if (error) begin
          state_d = S_FAULT;
        end else if (load) begin
          y_d          = data_in;
          load_pulse_d = 1'b1;
          state_d      = S_RUN;
        end else begin
          state_d = S_WAIT_Y;
        end
      end

      S_RUN: begin
        // The counter is zero only on the first RUN cycle; the launch is
        // suppressed when error is already forcing FAULT.
        launch_d = (cnt_q == '0) && !error;
        if (error) begin
          state_d = S_FAULT;
        end else if (done) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        if (error) begin
          state_d = S_FAULT;
        end else if (start) begin
          opcode_d = opcode;
          state_d  = start_target(opcode);
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status levels follow the state being entered so they register with it.
    busy_d  = (state_d == S_WAIT_X) || (state_d == S_WAIT_Y) || (state_d == S_RUN);
    ready_d = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      launch_q     <= 1'b0;
      load_pulse_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      opcode_q     <= 2'd0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      launch_q     <= launch_d;
      load_pulse_q <= load_pulse_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      opcode_q     <= opcode_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  assign Start     = launch_q;
  assign LoadData  = load_pulse_q;
  assign Ready     = ready_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign Opcode    = opcode_q;
  assign operand_x = x_q;
  assign operand_y = y_q;

endmodule

// File: tb/tb_operation_sequencer.sv
// Testbench for operation_sequencer: a directed vector table, hand-written
// timeout and asynchronous-reset sequences, then randomized stimulus checked
// against a transaction-level reference model.
module tb_operation_sequencer;

  localparam int W  = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, load, done, error;
  logic [1:0]    opcode;
  logic [W-1:0]  data_in;
  logic          Start, LoadData, Ready, busy, fault;
  logic [1:0]    Opcode;
  logic [W-1:0]  operand_x, operand_y;

  int vectors     = 0;
  int miscompares = 0;

  operation_sequencer #(.WORD_LENGTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .load(load), .opcode(opcode),
    .data_in(data_in), .done(done), .error(error), .Start(Start),
    .LoadData(LoadData), .Ready(Ready), .Opcode(Opcode), .operand_x(operand_x),
    .operand_y(operand_y), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // Expected-output record: {Start, LoadData, Ready, busy, fault, Opcode, x, y}
  typedef logic [38:0] outv_t;

  typedef struct packed {
    logic        st;
    logic        ld;
    logic [1:0]  op;
    logic [15:0] d;
    logic        dn;
    logic        er;
    outv_t       exp;
  } vec_t;

  function automatic outv_t pk(input logic s, input logic l, input logic r,
                               input logic b, input logic f, input logic [1:0] op,
                               input logic [15:0] x, input logic [15:0] y);
    pk = {s, l, r, b, f, op, x, y};
  endfunction

  function automatic vec_t mk(input logic st, input logic ld, input logic [1:0] op,
                              input logic [15:0] d, input logic dn, input logic er,
                              input outv_t exp);
    mk = '{st: st, ld: ld, op: op, d: d, dn: dn, er: er, exp: exp};
  endfunction

  task automatic check(input string name, input outv_t exp);
    outv_t got;
    got = {Start, LoadData, Ready, busy, fault, Opcode, operand_x, operand_y};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got S=%b L=%b R=%b B=%b F=%b op=%0d x=%h y=%h, required S=%b L=%b R=%b B=%b F=%b op=%0d x=%h y=%h",
               name, got[38], got[37], got[36], got[35], got[34], got[33:32], got[31:16], got[15:0],
               exp[38], exp[37], exp[36], exp[35], exp[34], exp[33:32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic drive(input logic st, input logic ld, input logic [1:0] op,
                       input logic [15:0] d, input logic dn, input logic er);
    @(negedge clk);
    start = st; load = ld; opcode = op; data_in = d; done = dn; error = er;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0; load = 1'b0; opcode = 2'd0; data_in = '0; done = 1'b0; error = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit        m_active;   // operation accepted, not yet finished
  int        m_loads;    // operands captured so far
  int        m_age;      // cycles spent running
  bit        m_ready, m_fault, m_start_p, m_load_p;
  logic [1:0]   m_op;
  logic [W-1:0] m_x, m_y;

  function automatic int needed(input logic [1:0] op);
    needed = (op == 2'd2) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_active = 0; m_loads = 0; m_age = 0; m_ready = 0; m_fault = 0;
    m_start_p = 0; m_load_p = 0; m_op = 2'd0; m_x = '0; m_y = '0;
  endtask

  task automatic model_step(input logic st, input logic ld, input logic [1:0] op,
                            input logic [15:0] d, input logic dn, input logic er);
    m_start_p = 0;
    m_load_p  = 0;
    if ((m_active || m_ready) && er) begin
      m_active = 0; m_ready = 0; m_fault = 1;
    end else if (m_active && m_loads < needed(m_op)) begin
      if (ld) begin
        if (m_loads == 0) begin
          m_x = d;
          if (m_op == 2'd2) m_y = '0;
        end else begin
          m_y = d;
        end
        m_loads++;
        m_load_p = 1;
        m_age = 0;
      end
    end else if (m_active) begin
      if (m_age == 0) m_start_p = 1;
      if (dn) begin
        m_active = 0; m_ready = 1;
      end else if (m_age == TO - 1) begin
        m_active = 0; m_fault = 1;
      end else begin
        m_age++;
      end
    end else if (st) begin
      m_op = op; m_ready = 0; m_fault = 0;
      if (op == 2'd3) m_fault = 1;
      else begin
        m_active = 1; m_loads = 0;
      end
    end
  endtask

  function automatic outv_t model_out();
    model_out = pk(m_start_p, m_load_p, m_ready, m_active, m_fault, m_op, m_x, m_y);
  endfunction

  vec_t tbl[22];

  initial begin
    reset = 1'b0;
    start = 1'b0; load = 1'b0; opcode = 2'd0; data_in = '0; done = 1'b0; error = 1'b0;

    tbl[0]  = mk(1, 0, 2'd0, 16'h0000, 0, 0, pk(0, 0, 0, 1, 0, 2'd0, 16'h0000, 16'h0000));
    tbl[1]  = mk(0, 1, 2'd0, 16'h0003, 0, 0, pk(0, 1, 0, 1, 0, 2'd0, 16'h0003, 16'h0000));
    tbl[2]  = mk(0, 1, 2'd0, 16'h0005, 0, 0, pk(0, 1, 0, 1, 0, 2'd0, 16'h0003, 16'h0005));
    tbl[3]  = mk(0, 0, 2'd0, 16'h0000, 0, 0, pk(1, 0, 0, 1, 0, 2'd0, 16'h0003, 16'h0005));
    tbl[4]  = mk(0, 0, 2'd0, 16'h0000, 1, 0, pk(0, 0, 1, 0, 0, 2'd0, 16'h0003, 16'h0005));
    tbl[5]  = mk(0, 0, 2'd0, 16'h0000, 0, 0, pk(0, 0, 1, 0, 0, 2'd0, 16'h0003, 16'h0005));
    tbl[6]  = mk(1, 1, 2'd2, 16'hFFFF, 0, 0, pk(0, 0, 0, 1, 0, 2'd2, 16'h0003, 16'h0005));
    tbl[7]  = mk(0, 1, 2'd0, 16'h0010, 0, 0, pk(0, 1, 0, 1, 0, 2'd2, 16'h0010, 16'h0000));
    tbl[8]  = mk(0, 0, 2'd0, 16'h0000, 0, 0, pk(1, 0, 0, 1, 0, 2'd2, 16'h0010, 16'h0000));
    tbl[9]  = mk(0, 0, 2'd0, 16'h0000, 1, 1, pk(0, 0, 0, 0, 1, 2'd2, 16'h0010, 16'h0000));
    tbl[10] = mk(1, 0, 2'd1, 16'h0000, 0, 0, pk(0, 0, 0, 1, 0, 2'd1, 16'h0010, 16'h0000));
    tbl[11] = mk(1, 0, 2'd3, 16'h0000, 0, 0, pk(0, 0, 0, 1, 0, 2'd1, 16'h0010, 16'h0000));
    tbl[12] = mk(0, 1, 2'd0, 16'hA5A5, 0, 1, pk(0, 0, 0, 0, 1, 2'd1, 16'h0010, 16'h0000));
    tbl[13] = mk(1, 0, 2'd3, 16'h0000, 0, 0, pk(0, 0, 0, 0, 1, 2'd3, 16'h0010, 16'h0000));
    tbl[14] = mk(0, 1, 2'd0, 16'h7777, 0, 0, pk(0, 0, 0, 0, 1, 2'd3, 16'h0010, 16'h0000));
    tbl[15] = mk(1, 0, 2'd1, 16'h0000, 0, 0, pk(0, 0, 0, 1, 0, 2'd1, 16'h0010, 16'h0000));
    tbl[16] = mk(0, 1, 2'd0, 16'h1111, 0, 0, pk(0, 1, 0, 1, 0, 2'd1, 16'h1111, 16'h0000));
    tbl[17] = mk(0, 0, 2'd0, 16'h0000, 1, 0, pk(0, 0, 0, 1, 0, 2'd1, 16'h1111, 16'h0000));
    tbl[18] = mk(0, 1, 2'd0, 16'h2222, 0, 0, pk(0, 1, 0, 1, 0, 2'd1, 16'h1111, 16'h2222));
    tbl[19] = mk(0, 0, 2'd0, 16'h0000, 0, 0, pk(1, 0, 0, 1, 0, 2'd1, 16'h1111, 16'h2222));
    tbl[20] = mk(0, 0, 2'd0, 16'h0000, 0, 0, pk(0, 0, 0, 1, 0, 2'd1, 16'h1111, 16'h2222));
    tbl[21] = mk(0, 0, 2'd0, 16'h0000, 0, 1, pk(0, 0, 0, 0, 1, 2'd1, 16'h1111, 16'h2222));

    // Directed table
    do_reset();
    #1;
    check("reset_state", pk(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000));
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].st, tbl[i].ld, tbl[i].op, tbl[i].d, tbl[i].dn, tbl[i].er);
      check($sformatf("table_%0d", i), tbl[i].exp);
    end

    // Timeout: no done for TO cycles in RUN
    do_reset();
    drive(1, 0, 2'd0, 16'h0000, 0, 0);
    check("to_start", pk(0, 0, 0, 1, 0, 2'd0, 16'h0000, 16'h0000));
    drive(0, 1, 2'd0, 16'h00AA, 0, 0);
    drive(0, 1, 2'd0, 16'h00BB, 0, 0);
    check("to_enter_run", pk(0, 1, 0, 1, 0, 2'd0, 16'h00AA, 16'h00BB));
    for (int i = 0; i < TO - 1; i++) begin
      drive(0, 0, 2'd0, 16'h0000, 0, 0);
      check($sformatf("to_run_%0d", i),
            pk((i == 0) ? 1'b1 : 1'b0, 0, 0, 1, 0, 2'd0, 16'h00AA, 16'h00BB));
    end
    drive(0, 0, 2'd0, 16'h0000, 0, 0);
    check("to_fault", pk(0, 0, 0, 0, 1, 2'd0, 16'h00AA, 16'h00BB));

    // Asynchronous reset in WAIT_Y, then start on the first edge after release
    do_reset();
    drive(1, 0, 2'd1, 16'h0000, 0, 0);
    drive(0, 1, 2'd0, 16'h1234, 0, 0);
    check("wy_before_reset", pk(0, 1, 0, 1, 0, 2'd1, 16'h1234, 16'h0000));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", pk(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000));
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1; load = 1'b0; opcode = 2'd3; data_in = '0; done = 1'b0; error = 1'b0;
    @(posedge clk);
    #1;
    check("invalid_op_fault", pk(0, 0, 0, 0, 1, 2'd3, 16'h0000, 16'h0000));
    drive(0, 0, 2'd0, 16'h0000, 0, 0);
    check("invalid_op_hold", pk(0, 0, 0, 0, 1, 2'd3, 16'h0000, 16'h0000));

    // Randomized stimulus against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      logic st, ld, dn, er;
      logic [1:0] op;
      logic [15:0] d;
      st = ($urandom_range(0, 3) == 0);
      ld = ($urandom_range(0, 2) == 0);
      op = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      dn = (i % 500 < 200) ? 1'b0 : ($urandom_range(0, 9) == 0);
      er = ($urandom_range(0, 59) == 0);
      model_step(st, ld, op, d, dn, er);
      drive(st, ld, op, d, dn, er);
      check($sformatf("rand_%0d", i), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
